// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl
//   Timekeeping and time-setting controller for the digital clock.
//   Counts hours/minutes/seconds from the 1 Hz tick in RUN mode and lets the
//   user adjust one field at a time in the SET_H / SET_M / SET_S modes. Each
//   field can be stepped once per button press or auto-repeated while held.
//
// Ports
//   clk_100MHz_i   system clock
//   reset_i        asynchronous reset, active low
//   second_tick_i  one-cycle pulse per second
//   inc_i, dec_i   debounced increment / decrement button levels
//   mode_i         debounced config button level
//   seconds_o      0..59
//   minutes_o      0..59
//   hours_o        0..23
//   mode_o         00 RUN, 01 SET_H, 10 SET_M, 11 SET_S
//   blink_o        1 = blank the selected field right now
module clock_set_ctrl #(
   parameter int REPEAT_DELAY  = 50_000_000,
   parameter int REPEAT_PERIOD = 10_000_000
) (
   input  logic       clk_100MHz_i,
   input  logic       reset_i,
   input  logic       second_tick_i,
   input  logic       inc_i,
   input  logic       dec_i,
   input  logic       mode_i,
   output logic [5:0] seconds_o,
   output logic [5:0] minutes_o,
   output logic [4:0] hours_o,
   output logic [1:0] mode_o,
   output logic       blink_o
);

   localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] DELAY_C   = CW'(REPEAT_DELAY);
   localparam logic [CW-1:0] PERIOD_C  = CW'(REPEAT_PERIOD);
   localparam logic [CW-1:0] CNT_MAX_C = CW'(CNT_MAX);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   typedef enum logic [1:0] {
      RUN   = 2'b00,
      SET_H = 2'b01,
      SET_M = 2'b10,
      SET_S = 2'b11
   } mode_t;

   mode_t         mode_q, mode_d;
   logic [5:0]    sec_q, sec_d;
   logic [5:0]    min_q, min_d;
   logic [4:0]    hr_q, hr_d;
   logic          blink_q, blink_d;
   // Hold counter: 0 = idle (not armed). It is armed only by a button edge,
   // so a level that was already high (e.g. through reset or a mode change)
   // never starts auto-repeat.
   logic [CW-1:0] cnt_q, cnt_d;
   // rep_q: first repeat step already taken, now pacing at REPEAT_PERIOD.
   logic          rep_q, rep_d;
   logic          inc_prev_q, inc_prev_d;
   logic          dec_prev_q, dec_prev_d;
   logic          mode_prev_q, mode_prev_d;

   logic inc_e, dec_e, mode_e, solo;
   logic rep_step, step_up, step_dn;

   always_comb begin
      inc_e  = inc_i  & ~inc_prev_q;
      dec_e  = dec_i  & ~dec_prev_q;
      mode_e = mode_i & ~mode_prev_q;
      solo   = inc_i ^ dec_i;

      mode_d      = mode_q;
      sec_d       = sec_q;
      min_d       = min_q;
      hr_d        = hr_q;
      blink_d     = blink_q;
      cnt_d       = cnt_q;
      rep_d       = rep_q;
      inc_prev_d  = inc_i;
      dec_prev_d  = dec_i;
      mode_prev_d = mode_i;
      rep_step    = 1'b0;
      step_up     = 1'b0;
      step_dn     = 1'b0;

      if (mode_q == RUN) begin
         cnt_d   = '0;
         rep_d   = 1'b0;
         blink_d = 1'b0;
         if (second_tick_i) begin
            if (sec_q == 6'd59) begin
               sec_d = 6'd0;
               if (min_q == 6'd59) begin
                  min_d = 6'd0;
                  hr_d  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
               end else begin
                  min_d = min_q + 6'd1;
               end
            end else begin
               sec_d = sec_q + 6'd1;
            end
         end
      end else if (mode_e) begin
         // Mode change wins over any step or tick in this cycle.
         cnt_d = '0;
         rep_d = 1'b0;
      end else begin
         if (!solo) begin
            cnt_d = '0;
            rep_d = 1'b0;
         end else if (inc_e | dec_e) begin
            // Edge cycle counts as 0, so the next cycle sees 1.
            cnt_d = CNT_ONE;
            rep_d = 1'b0;
         end else if (cnt_q != '0) begin
            if (rep_q ? (cnt_q == PERIOD_C) : (cnt_q == DELAY_C)) begin
               rep_step = 1'b1;
               cnt_d    = CNT_ONE;
               rep_d    = 1'b1;
            end else if (cnt_q != CNT_MAX_C) begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         step_up = (inc_e & ~dec_e) | (rep_step & inc_i);
         step_dn = (dec_e & ~inc_e) | (rep_step & dec_i);

         if (step_up) begin
            case (mode_q)
               SET_H:   hr_d  = (hr_q  == 5'd23) ? 5'd0 : hr_q  + 5'd1;
               SET_M:   min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
               default: sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
            endcase
         end else if (step_dn) begin
            case (mode_q)
               SET_H:   hr_d  = (hr_q  == 5'd0) ? 5'd23 : hr_q  - 5'd1;
               SET_M:   min_d = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
               default: sec_d = (sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1;
            endcase
         end

         // A step shows the new value immediately; otherwise blink at 1 Hz.
         if (step_up | step_dn) begin
            blink_d = 1'b0;
         end else if (second_tick_i) begin
            blink_d = ~blink_q;
         end
      end

      if (mode_e) begin
         mode_d  = mode_t'(mode_q + 2'd1);
         blink_d = 1'b0;
      end
   end

   always_ff @(posedge clk_100MHz_i or negedge reset_i) begin
      if (!reset_i) begin
         mode_q      <= RUN;
         sec_q       <= '0;
         min_q       <= '0;
         hr_q        <= '0;
         blink_q     <= 1'b0;
         cnt_q       <= '0;
         rep_q       <= 1'b0;
         // History starts high so a button held through reset is not an edge.
         inc_prev_q  <= 1'b1;
         dec_prev_q  <= 1'b1;
         mode_prev_q <= 1'b1;
      end else begin
         mode_q      <= mode_d;
         sec_q       <= sec_d;
         min_q       <= min_d;
         hr_q        <= hr_d;
         blink_q     <= blink_d;
         cnt_q       <= cnt_d;
         rep_q       <= rep_d;
         inc_prev_q  <= inc_prev_d;
         dec_prev_q  <= dec_prev_d;
         mode_prev_q <= mode_prev_d;
      end
   end

   assign seconds_o = sec_q;
   assign minutes_o = min_q;
   assign hours_o   = hr_q;
   assign mode_o    = mode_q;
   assign blink_o   = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed scenarios with literal expectations,
// then randomized buttons/ticks, all checked every cycle against a model
// that keeps time as a count of seconds in the day.
module tb_clock_set_ctrl;

   localparam int D = 10;
   localparam int P = 4;

   logic       clk;
   logic       reset_i;
   logic       second_tick_i, inc_i, dec_i, mode_i;
   logic [5:0] seconds_o, minutes_o;
   logic [4:0] hours_o;
   logic [1:0] mode_o;
   logic       blink_o;

   clock_set_ctrl #(.REPEAT_DELAY(D), .REPEAT_PERIOD(P)) dut (
      .clk_100MHz_i (clk),
      .reset_i      (reset_i),
      .second_tick_i(second_tick_i),
      .inc_i        (inc_i),
      .dec_i        (dec_i),
      .mode_i       (mode_i),
      .seconds_o    (seconds_o),
      .minutes_o    (minutes_o),
      .hours_o      (hours_o),
      .mode_o       (mode_o),
      .blink_o      (blink_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // t: seconds since midnight. k: cycles since the arming button edge, -1 = idle.
   typedef struct {
      int t;
      int mode;
      int k;
      bit blink;
      bit pi, pd, pm;
   } mstate_t;

   localparam mstate_t RST = '{t: 0, mode: 0, k: -1, blink: 1'b0, pi: 1'b1, pd: 1'b1, pm: 1'b1};

   function automatic mstate_t nxt(mstate_t s, bit tk, bit inc, bit dec, bit md);
      mstate_t n;
      bit ie, de, me, solo;
      int h, m, sc, kc, dir;
      n    = s;
      ie   = inc & !s.pi;
      de   = dec & !s.pd;
      me   = md & !s.pm;
      solo = inc ^ dec;
      h    = s.t / 3600;
      m    = (s.t / 60) % 60;
      sc   = s.t % 60;
      dir  = 0;
      if (s.mode == 0) begin
         if (tk) n.t = (s.t + 1) % 86400;
         n.k     = -1;
         n.blink = 1'b0;
      end else if (me) begin
         n.k = -1;
      end else begin
         kc = (ie || de) ? 0 : s.k;
         if (ie && !de) dir = 1;
         else if (de && !ie) dir = -1;
         else if (solo && kc >= D && ((kc - D) % P) == 0) dir = inc ? 1 : -1;
         if (dir != 0) begin
            case (s.mode)
               1:       h  = (h + dir + 24) % 24;
               2:       m  = (m + dir + 60) % 60;
               default: sc = (sc + dir + 60) % 60;
            endcase
            n.t     = h * 3600 + m * 60 + sc;
            n.blink = 1'b0;
         end else if (tk) begin
            n.blink = !s.blink;
         end
         n.k = (solo && kc >= 0) ? kc + 1 : -1;
      end
      if (me) begin
         n.mode  = (s.mode + 1) % 4;
         n.blink = 1'b0;
      end
      n.pi = inc;
      n.pd = dec;
      n.pm = md;
      return n;
   endfunction

   mstate_t ms = RST;

   always @(posedge clk or negedge reset_i) begin
      if (!reset_i) ms <= RST;
      else          ms <= nxt(ms, second_tick_i, inc_i, dec_i, mode_i);
   end

   // ---------------- per-cycle compare ----------------
   int  n_cmp_mdl = 0;
   int  n_err_mdl = 0;
   bit  cmp_en    = 1'b0;

   always @(negedge clk) begin
      if (cmp_en) begin
         n_cmp_mdl++;
         if (int'(hours_o) != ms.t / 3600 || int'(minutes_o) != (ms.t / 60) % 60 ||
             int'(seconds_o) != ms.t % 60 || int'(mode_o) != ms.mode || blink_o != ms.blink) begin
            n_err_mdl++;
            $display("FAIL model_cmp @%0t: got %0d:%0d:%0d mode=%0d blink=%0d expected %0d:%0d:%0d mode=%0d blink=%0d",
                     $time, hours_o, minutes_o, seconds_o, mode_o, blink_o,
                     ms.t / 3600, (ms.t / 60) % 60, ms.t % 60, ms.mode, ms.blink);
         end
      end
   end

   // ---------------- directed helpers ----------------
   int n_cmp_lit = 0;
   int n_err_lit = 0;

   task automatic chk(input string nm, input int got, input int exp);
      n_cmp_lit++;
      if (got != exp) begin
         n_err_lit++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic clk1();
      @(posedge clk);
      #2;
   endtask

   // One-cycle high pulse on the chosen inputs, then one idle cycle.
   task automatic press(input bit i, input bit d, input bit m, input bit t);
      inc_i = i; dec_i = d; mode_i = m; second_tick_i = t;
      clk1();
      inc_i = 0; dec_i = 0; mode_i = 0; second_tick_i = 0;
      clk1();
   endtask

   task automatic chk_time(input string nm, input int h, input int m, input int s);
      chk({nm, "_h"}, int'(hours_o), h);
      chk({nm, "_m"}, int'(minutes_o), m);
      chk({nm, "_s"}, int'(seconds_o), s);
   endtask

   initial begin
      reset_i = 1'b1;
      inc_i = 0; dec_i = 0; mode_i = 0; second_tick_i = 0;
      #1 reset_i = 1'b0;
      #1 cmp_en = 1'b1;
      clk1(); clk1();
      chk_time("reset", 0, 0, 0);
      chk("reset_mode", int'(mode_o), 0);
      chk("reset_blink", int'(blink_o), 0);
      reset_i = 1'b1;
      clk1(); clk1();

      // Set-mode wrap on hours
      press(0, 0, 1, 0);
      chk("setwrap_mode", int'(mode_o), 1);
      press(0, 1, 0, 0);
      chk("setwrap_dec_h", int'(hours_o), 23);
      press(1, 0, 0, 0);
      chk_time("setwrap_inc", 0, 0, 0);

      // Rollover: 23:59:58 then two ticks
      press(0, 1, 0, 0);
      press(0, 0, 1, 0);
      press(0, 1, 0, 0);
      press(0, 0, 1, 0);
      press(0, 1, 0, 0);
      press(0, 1, 0, 0);
      chk_time("preset", 23, 59, 58);
      press(0, 0, 1, 0);
      chk("rollover_mode", int'(mode_o), 0);
      press(0, 0, 0, 1);
      chk_time("rollover1", 23, 59, 59);
      press(0, 0, 0, 1);
      chk_time("rollover2", 0, 0, 0);

      // Auto-repeat in SET_M
      press(0, 0, 1, 0);
      press(0, 0, 1, 0);
      chk("rep_mode", int'(mode_o), 2);
      inc_i = 1;
      repeat (24) clk1();
      inc_i = 0;
      clk1();
      chk("repeat24", int'(minutes_o), 5);
      inc_i = 1;
      repeat (9) clk1();
      inc_i = 0;
      clk1();
      chk("repeat9", int'(minutes_o), 6);

      // Frozen time and blink in SET_S
      press(0, 0, 1, 0);
      repeat (7) press(1, 0, 0, 0);
      chk("frozen_pre", int'(seconds_o), 7);
      repeat (5) press(0, 0, 0, 1);
      chk("frozen_s", int'(seconds_o), 7);
      chk("frozen_blink", int'(blink_o), 1);
      press(1, 0, 0, 0);
      chk("step_s", int'(seconds_o), 8);
      chk("step_blink", int'(blink_o), 0);

      // Simultaneous events in SET_H
      press(0, 0, 1, 0);
      press(0, 0, 1, 0);
      repeat (3) press(1, 0, 0, 0);
      chk("simul_pre", int'(hours_o), 3);
      press(1, 1, 0, 0);
      chk("incdec_h", int'(hours_o), 3);
      press(1, 0, 1, 0);
      chk("modeinc_mode", int'(mode_o), 2);
      chk("modeinc_h", int'(hours_o), 3);

      // Reset with inc held, then no step until re-pressed
      inc_i = 1;
      repeat (3) clk1();
      chk("held_m", int'(minutes_o), 7);
      reset_i = 1'b0;
      #1;
      chk_time("midreset", 0, 0, 0);
      chk("midreset_mode", int'(mode_o), 0);
      clk1();
      reset_i = 1'b1;
      clk1();
      mode_i = 1; clk1(); mode_i = 0; clk1();
      mode_i = 1; clk1(); mode_i = 0; clk1();
      repeat (15) clk1();
      chk("held_mode", int'(mode_o), 2);
      chk("held_no_step", int'(minutes_o), 0);
      inc_i = 0; clk1();
      inc_i = 1; clk1();
      chk("repress_m", int'(minutes_o), 1);
      inc_i = 0; clk1();

      // Randomized stimulus
      for (int c = 0; c < 3000; c++) begin
         second_tick_i = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 15) == 0) inc_i  = ~inc_i;
         if ($urandom_range(0, 15) == 0) dec_i  = ~dec_i;
         if ($urandom_range(0, 29) == 0) mode_i = ~mode_i;
         if (c == 1500) begin
            reset_i = 1'b0;
            clk1();
            reset_i = 1'b1;
         end
         clk1();
      end
      inc_i = 0; dec_i = 0; mode_i = 0; second_tick_i = 0;
      clk1(); clk1();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp_lit + n_cmp_mdl, n_err_lit + n_err_mdl);
      $finish;
   end

endmodule
